// File: rtl/ac_sweep_pkg.sv
// Shared types and helpers for the AC sweep peak finder.
// Optional down-sweep support is enabled with AC_SWEEP_PEAK_FINDER_BIDIR_EN.
package ac_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_MEASURE,
    S_UPDATE,
    S_DONE
  } sweep_state_e;

  localparam int unsigned DEF_MAG_W    = 16;
  localparam int unsigned DEF_AVG_LOG2 = 2;
  localparam int unsigned ACC_W        = DEF_MAG_W + DEF_AVG_LOG2;

  // Widest packed bus and widest lane the slice helper handles.
  localparam int unsigned PACK_W  = 1024;
  localparam int unsigned SLICE_W = 64;

  function automatic int unsigned acc_width(
    input int unsigned mag_w,
    input int unsigned avg_log2
  );
    return mag_w + avg_log2;
  endfunction

  function automatic logic [SLICE_W-1:0] ch_slice(
    input logic [PACK_W-1:0] v,
    input int unsigned       c,
    input int unsigned       w
  );
    logic [PACK_W-1:0] s;
    s = v >> (c * w);
    return s[SLICE_W-1:0];
  endfunction

endpackage

// File: rtl/ac_sweep_ch_tracker.sv
// Per-channel sample accumulator and resonance peak tracker.
// Macro AC_SWEEP_PEAK_FINDER_BIDIR_EN does not affect this block.
module ac_sweep_ch_tracker
  import ac_sweep_pkg::*;
#(
  parameter int unsigned FREQ_W   = 32,
  parameter int unsigned MAG_W    = DEF_MAG_W,
  parameter int unsigned NPTS_W   = 10,
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              acc_clr_i,
  input  logic              acc_en_i,
  input  logic              upd_i,
  input  logic [MAG_W-1:0]  mag_i,
  input  logic [FREQ_W-1:0] freq_i,
  input  logic [NPTS_W-1:0] idx_i,
  output logic [MAG_W-1:0]  peak_mag_o,
  output logic [FREQ_W-1:0] peak_freq_o,
  output logic [NPTS_W-1:0] peak_idx_o
);

  localparam int unsigned AW = acc_width(MAG_W, AVG_LOG2);

  logic [AW-1:0]     acc_q;
  logic [MAG_W-1:0]  avg;
  logic              hit;
  logic [MAG_W-1:0]  pk_mag_q;
  logic [FREQ_W-1:0] pk_freq_q;
  logic [NPTS_W-1:0] pk_idx_q;

  assign avg = MAG_W'(acc_q >> AVG_LOG2);
  // Strict compare keeps the earliest point on ties.
  assign hit = avg > pk_mag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr_i) begin
      acc_q <= '0;
    end else if (acc_en_i) begin
      acc_q <= acc_q + AW'(mag_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_mag_q  <= '0;
      pk_freq_q <= '0;
      pk_idx_q  <= '0;
    end else if (clr_i) begin
      pk_mag_q  <= '0;
      pk_freq_q <= '0;
      pk_idx_q  <= '0;
    end else if (upd_i && hit) begin
      pk_mag_q  <= avg;
      pk_freq_q <= freq_i;
      pk_idx_q  <= idx_i;
    end
  end

  assign peak_mag_o  = pk_mag_q;
  assign peak_freq_o = pk_freq_q;
  assign peak_idx_o  = pk_idx_q;

endmodule

// File: rtl/ac_sweep_peak_finder.sv
// Stepped-frequency AC sweep controller with per-channel peak tracking.
// Define AC_SWEEP_PEAK_FINDER_BIDIR_EN to add the dir_down input.
module ac_sweep_peak_finder
  import ac_sweep_pkg::*;
#(
  parameter int unsigned FREQ_W   = 32,
  parameter int unsigned MAG_W    = 16,
  parameter int unsigned CH       = 2,
  parameter int unsigned NPTS_W   = 10,
  parameter int unsigned SETTLE_W = 12,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [FREQ_W-1:0]    f_start,
  input  logic [FREQ_W-1:0]    f_step,
  input  logic [NPTS_W-1:0]    n_points,
  input  logic [SETTLE_W-1:0]  settle_cycles,
`ifdef AC_SWEEP_PEAK_FINDER_BIDIR_EN
  input  logic                 dir_down,
`endif
  input  logic                 mag_valid,
  input  logic [CH*MAG_W-1:0]  mag,
  output logic [FREQ_W-1:0]    freq_out,
  output logic                 freq_load,
  output logic                 busy,
  output logic                 done,
  output logic [CH*MAG_W-1:0]  peak_mag,
  output logic [CH*FREQ_W-1:0] peak_freq,
  output logic [CH*NPTS_W-1:0] peak_idx
);

  localparam int unsigned SCW = AVG_LOG2 + 1;
  localparam logic [SCW-1:0] SAMP_LAST =
    SCW'((1 << AVG_LOG2) - 1);

  sweep_state_e state_q, state_d;

  logic [FREQ_W-1:0]   freq_q;
  logic [FREQ_W-1:0]   step_q;
  logic [NPTS_W-1:0]   npts_q;
  logic [NPTS_W-1:0]   idx_q;
  logic [SETTLE_W-1:0] sinit_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SCW-1:0]      samp_q;
  logic                dir_dn;

  logic go, acc_clr, acc_en, upd, adv;
  logic last_pt, last_samp;

  assign last_pt   = idx_q == npts_q - NPTS_W'(1);
  assign last_samp = samp_q == SAMP_LAST;

`ifdef AC_SWEEP_PEAK_FINDER_BIDIR_EN
  logic dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else if (go) begin
      dir_q <= dir_down;
    end
  end

  assign dir_dn = dir_q;
`else
  assign dir_dn = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    upd     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          go      = 1'b1;
          state_d = (n_points == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: state_d = S_SETTLE;
      S_SETTLE: begin
        if (settle_q == '0) begin
          acc_clr = 1'b1;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        acc_en = mag_valid;
        if (mag_valid && last_samp) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        upd     = 1'b1;
        adv     = !last_pt;
        state_d = last_pt ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins everywhere outside IDLE; the open point is dropped.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      upd     = 1'b0;
      adv     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q   <= '0;
      step_q   <= '0;
      npts_q   <= '0;
      idx_q    <= '0;
      sinit_q  <= '0;
      settle_q <= '0;
      samp_q   <= '0;
    end else begin
      if (go) begin
        step_q  <= f_step;
        npts_q  <= n_points;
        sinit_q <= settle_cycles;
        idx_q   <= '0;
        if (n_points != '0) begin
          freq_q <= f_start;
        end
      end
      if (state_q == S_LOAD) begin
        settle_q <= sinit_q;
      end else if (state_q == S_SETTLE && settle_q != '0) begin
        settle_q <= settle_q - SETTLE_W'(1);
      end
      if (acc_clr) begin
        samp_q <= '0;
      end else if (acc_en) begin
        samp_q <= samp_q + SCW'(1);
      end
      if (adv) begin
        freq_q <= dir_dn ? freq_q - step_q : freq_q + step_q;
        idx_q  <= idx_q + NPTS_W'(1);
      end
    end
  end

  assign freq_out  = freq_q;
  assign freq_load = state_q == S_LOAD;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [MAG_W-1:0] mag_c;

    assign mag_c = MAG_W'(ch_slice(PACK_W'(mag), c, MAG_W));

    ac_sweep_ch_tracker #(
      .FREQ_W   (FREQ_W),
      .MAG_W    (MAG_W),
      .NPTS_W   (NPTS_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_trk (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (go),
      .acc_clr_i   (acc_clr),
      .acc_en_i    (acc_en),
      .upd_i       (upd),
      .mag_i       (mag_c),
      .freq_i      (freq_q),
      .idx_i       (idx_q),
      .peak_mag_o  (peak_mag[c*MAG_W +: MAG_W]),
      .peak_freq_o (peak_freq[c*FREQ_W +: FREQ_W]),
      .peak_idx_o  (peak_idx[c*NPTS_W +: NPTS_W])
    );
  end

endmodule

// File: tb/tb_ac_sweep_peak_finder.sv
// Randomized bench for ac_sweep_peak_finder against a per-sweep reference model.
// Covers the dir_down port when AC_SWEEP_PEAK_FINDER_BIDIR_EN is defined.
module tb_ac_sweep_peak_finder;

  localparam int FW   = 32;
  localparam int MW   = 16;
  localparam int CH   = 2;
  localparam int NW   = 10;
  localparam int SW   = 12;
  localparam int NS   = 4;
  localparam int MAXP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic mag_valid = 1'b0;
  logic dir_down = 1'b0;
  logic [FW-1:0] f_start = '0;
  logic [FW-1:0] f_step = '0;
  logic [NW-1:0] n_points = '0;
  logic [SW-1:0] settle_cycles = '0;
  logic [CH*MW-1:0] mag = '0;

  logic [FW-1:0]    freq_out;
  logic             freq_load;
  logic             busy;
  logic             done;
  logic [CH*MW-1:0] peak_mag;
  logic [CH*FW-1:0] peak_freq;
  logic [CH*NW-1:0] peak_idx;

  int n_chk = 0;
  int n_err = 0;
  int unsigned samp [MAXP][NS][CH];
  logic [FW-1:0] fl_q [$];
  int done_cnt = 0;

  always #5 clk = ~clk;

  ac_sweep_peak_finder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .f_start       (f_start),
    .f_step        (f_step),
    .n_points      (n_points),
    .settle_cycles (settle_cycles),
`ifdef AC_SWEEP_PEAK_FINDER_BIDIR_EN
    .dir_down      (dir_down),
`endif
    .mag_valid     (mag_valid),
    .mag           (mag),
    .freq_out      (freq_out),
    .freq_load     (freq_load),
    .busy          (busy),
    .done          (done),
    .peak_mag      (peak_mag),
    .peak_freq     (peak_freq),
    .peak_idx      (peak_idx)
  );

  always @(negedge clk) begin
    if (freq_load) fl_q.push_back(freq_out);
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_freq_out"}, freq_out, 0);
    check({tag, "_freq_load"}, freq_load, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_peak_mag"}, peak_mag, 0);
    check({tag, "_peak_freq"}, peak_freq, 0);
    check({tag, "_peak_idx"}, peak_idx, 0);
  endtask

  task automatic garbage();
    mag_valid = 1'($urandom_range(1));
    mag = $urandom;
  endtask

  function automatic logic [FW-1:0] efreq(input logic [FW-1:0] fs,
      input logic [FW-1:0] st, input int p, input bit down);
    logic [FW-1:0] f;
    f = fs;
    for (int i = 0; i < p; i++) f = down ? f - st : f + st;
    return f;
  endfunction

  task automatic fill_rand(input int unsigned lo, input int unsigned hi);
    for (int p = 0; p < MAXP; p++)
      for (int k = 0; k < NS; k++)
        for (int c = 0; c < CH; c++)
          samp[p][k][c] = $urandom_range(hi, lo);
  endtask

  task automatic run_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] st,
      input int n, input int s, input bit dn, input int abort_pt,
      input int rst_pt);
    int pts, w, k;
    bit stop, aborted, resetted, down;
    int unsigned pk, sum, avg;
    logic [FW-1:0] pf;
    int pi;
    fl_q.delete();
    done_cnt = 0;
    f_start = fs;
    f_step = st;
    n_points = NW'(n);
    settle_cycles = SW'(s);
    dir_down = dn;
    down = dir_down;
    start = 1'b1;
    garbage();
    @(negedge clk);
    start = 1'b0;
    f_start = $urandom;
    f_step = $urandom;
    n_points = NW'($urandom);
    settle_cycles = SW'($urandom);
    dir_down = ~dn;
    stop = 0;
    aborted = 0;
    resetted = 0;
    pts = n;
    for (int p = 0; p < n && !stop; p++) begin
      w = 0;
      while (freq_load !== 1'b1 && w < 64) begin
        garbage();
        @(negedge clk);
        w++;
      end
      if (w >= 64) begin
        check("load_wait", {63'b0, freq_load}, 1);
        stop = 1;
        pts = p;
        break;
      end
      if (p == abort_pt) begin
        garbage();
        @(negedge clk);
        abort = 1'b1;
        garbage();
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        stop = 1;
        aborted = 1;
        pts = p;
        break;
      end
      for (int j = 0; j < s + 2; j++) begin
        start = (p == 1 && j == 1);
        garbage();
        @(negedge clk);
      end
      start = 1'b0;
      k = 0;
      while (k < NS) begin
        if ($urandom_range(3) == 0) begin
          mag_valid = 1'b0;
          mag = $urandom;
        end else begin
          mag_valid = 1'b1;
          mag = {MW'(samp[p][k][1]), MW'(samp[p][k][0])};
          k++;
        end
        @(negedge clk);
        if (p == rst_pt && k == 2) begin
          #2 rst = 1'b1;
          #1 check_zero("async_rst");
          @(negedge clk);
          rst = 1'b0;
          mag_valid = 1'b0;
          stop = 1;
          resetted = 1;
          break;
        end
      end
    end
    if (resetted) return;
    w = 0;
    while (busy && w < 64) begin
      garbage();
      @(negedge clk);
      w++;
    end
    mag_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_end", busy, 0);
    check("done_cnt", done_cnt, aborted ? 0 : 1);
    check("load_cnt", fl_q.size(), aborted ? pts + 1 : n);
    foreach (fl_q[i]) check("freq_seq", fl_q[i], efreq(fs, st, i, down));
    if (aborted) check("freq_hold", freq_out, efreq(fs, st, pts, down));
    for (int c = 0; c < CH; c++) begin
      pk = 0;
      pf = '0;
      pi = 0;
      for (int p = 0; p < pts; p++) begin
        sum = 0;
        for (int q = 0; q < NS; q++) sum += samp[p][q][c];
        avg = sum / NS;
        if (avg > pk) begin
          pk = avg;
          pf = efreq(fs, st, p, down);
          pi = p;
        end
      end
      check($sformatf("peak_mag%0d", c), peak_mag[c*MW +: MW], pk);
      check($sformatf("peak_freq%0d", c), peak_freq[c*FW +: FW], pf);
      check($sformatf("peak_idx%0d", c), peak_idx[c*NW +: NW], pi);
    end
  endtask

  initial begin
    int unsigned prof [5];
    int unsigned trunc [NS];
    bit dn;
    prof = '{10, 40, 90, 40, 10};
    trunc = '{1, 2, 2, 2};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int p = 0; p < 5; p++)
      for (int k = 0; k < NS; k++) begin
        samp[p][k][0] = prof[p];
        samp[p][k][1] = 7;
      end
    run_sweep(1000, 100, 5, 3, 0, -1, -1);

    for (int k = 0; k < NS; k++) begin
      samp[0][k][0] = trunc[k];
      samp[0][k][1] = (k == 3) ? 3 : 0;
    end
    run_sweep(500, 1, 1, 0, 0, -1, -1);

    run_sweep(77, 5, 0, 2, 0, -1, -1);

    fill_rand(1, 40);
    run_sweep(2000, 50, 6, 2, 0, 3, -1);
    fill_rand(0, 40);
    run_sweep(3000, 7, 4, 1, 0, -1, -1);

    fill_rand(4, 60);
    run_sweep(4000, 9, 5, 1, 0, -1, 2);
    fill_rand(0, 60);
    run_sweep(5000, 11, 3, 0, 0, -1, -1);

    run_sweep(32'hFFFF_FFF0, 32'h20, 2, 1, 0, -1, -1);
`ifdef AC_SWEEP_PEAK_FINDER_BIDIR_EN
    run_sweep(32'h10, 32'h20, 2, 1, 1, -1, -1);
`endif

    for (int r = 0; r < 6; r++) begin
      dn = 1'b0;
`ifdef AC_SWEEP_PEAK_FINDER_BIDIR_EN
      dn = 1'($urandom_range(1));
`endif
      fill_rand(0, 30);
      run_sweep($urandom, $urandom, $urandom_range(10, 1),
                $urandom_range(5, 0), dn, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
